// File: rtl/pitch_track.sv
// pitch_track: measures the fundamental period of a signed audio stream, in samples.
// A Schmitt comparator squares the input. A SEEK/MEASURE lock FSM counts samples
// between accepted rising crossings.
// Optional macro PITCH_TRACK_SMOOTH_EN enables one-pole smoothing of the period.
// Ports:
//   sample_clk    - clock, one cycle per audio sample
//   rst_n         - asynchronous active-low reset
//   sample_in     - signed W-bit audio sample
//   period_out    - last measured (or smoothed) period, P bits
//   period_valid  - high while locked
//   period_strobe - one-cycle pulse on each period_out update
//   square_out    - Schmitt comparator state
module pitch_track #(
   parameter int unsigned  W            = 16,
   parameter int unsigned  HYST         = 256,
   parameter int unsigned  MIN_PERIOD   = 8,
   parameter int unsigned  MAX_PERIOD   = 2047,
   parameter int unsigned  SMOOTH_SHIFT = 2,
   localparam int unsigned P            = $clog2(MAX_PERIOD + 1)
) (
   input  logic                sample_clk,
   input  logic                rst_n,
   input  logic signed [W-1:0] sample_in,
   output logic        [P-1:0] period_out,
   output logic                period_valid,
   output logic                period_strobe,
   output logic                square_out
);

   // Reject configurations the counter logic cannot honour.
   if (MIN_PERIOD < 1 || MIN_PERIOD > MAX_PERIOD || SMOOTH_SHIFT > P || HYST < 1) begin : g_bad_cfg
      $error("pitch_track: invalid parameter combination");
   end

   localparam logic signed [W-1:0] HYST_POS = W'(HYST);
   localparam logic signed [W-1:0] HYST_NEG = -HYST_POS;

   typedef enum logic {
      S_SEEK    = 1'b0,
      S_MEASURE = 1'b1
   } state_t;

   state_t       r_state;
   logic [P-1:0] r_cnt;
   logic         w_above;
   logic         w_below;
   logic         w_rise;
   logic         w_accept;
   logic [P-1:0] w_next_period;

   assign w_above  = sample_in > HYST_POS;
   assign w_below  = sample_in < HYST_NEG;
   assign w_rise   = !square_out && w_above;
   assign w_accept = w_rise && (r_cnt >= P'(MIN_PERIOD));

`ifdef PITCH_TRACK_SMOOTH_EN
   // period + ((m - period) >>> SMOOTH_SHIFT); the low P bits of the sum are exact.
   logic signed [P:0] w_diff;
   logic signed [P:0] w_step;
   logic        [P-1:0] w_sum;

   assign w_diff        = $signed({1'b0, r_cnt}) - $signed({1'b0, period_out});
   assign w_step        = w_diff >>> SMOOTH_SHIFT;
   assign w_sum         = period_out + P'(w_step);
   // First edge after SEEK loads the raw measurement.
   assign w_next_period = period_valid ? w_sum : r_cnt;
`else
   assign w_next_period = r_cnt;
`endif

   // Schmitt comparator.
   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) begin
         square_out <= 1'b0;
      end else if (!square_out && w_above) begin
         square_out <= 1'b1;
      end else if (square_out && w_below) begin
         square_out <= 1'b0;
      end
   end

   // Lock FSM, period counter and period outputs.
   always_ff @(posedge sample_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_SEEK;
         r_cnt         <= '0;
         period_out    <= '0;
         period_valid  <= 1'b0;
         period_strobe <= 1'b0;
      end else begin
         period_strobe <= 1'b0;
         case (r_state)
            S_SEEK: begin
               if (w_rise) begin
                  r_state <= S_MEASURE;
                  r_cnt   <= P'(1);
               end else begin
                  r_cnt   <= '0;
               end
            end
            S_MEASURE: begin
               // An accepted edge takes priority over the timeout at MAX_PERIOD.
               if (w_accept) begin
                  period_out    <= w_next_period;
                  period_strobe <= 1'b1;
                  period_valid  <= 1'b1;
                  r_cnt         <= P'(1);
               end else if (r_cnt == P'(MAX_PERIOD)) begin
                  r_state      <= S_SEEK;
                  r_cnt        <= '0;
                  period_valid <= 1'b0;
               end else begin
                  r_cnt <= r_cnt + P'(1);
               end
            end
            default: begin
               r_state <= S_SEEK;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pitch_track.sv
// Directed testbench for pitch_track with default parameters.
// Each sample is applied before a rising edge, and the outputs are read 1 time unit after that edge.
module tb_pitch_track;

   localparam int unsigned P = 11;

   logic               sample_clk = 1'b0;
   logic               rst_n;
   logic signed [15:0] sample_in;
   logic [P-1:0]       period_out;
   logic               period_valid;
   logic               period_strobe;
   logic               square_out;

   int n_vec = 0;
   int n_err = 0;

   pitch_track dut (
      .sample_clk    (sample_clk),
      .rst_n         (rst_n),
      .sample_in     (sample_in),
      .period_out    (period_out),
      .period_valid  (period_valid),
      .period_strobe (period_strobe),
      .square_out    (square_out)
   );

   always #5 sample_clk = ~sample_clk;

   // Square wave: +10000 in the first half of each period, -10000 in the second half.
   function automatic logic signed [15:0] wave(input int i, input int per);
      return ((i % per) < (per / 2)) ? 16'sd10000 : -16'sd10000;
   endfunction

   task automatic step(input logic signed [15:0] v);
      sample_in = v;
      @(posedge sample_clk);
      #1;
   endtask

   task automatic do_reset;
      rst_n     = 1'b0;
      sample_in = '0;
      repeat (2) @(posedge sample_clk);
      @(negedge sample_clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      rst_n     = 1'b0;
      sample_in = '0;
      #3;
      n_vec++; if (period_out !== '0)    begin n_err++; $display("FAIL reset_period: got %0d want 0", period_out); end
      n_vec++; if (period_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", period_valid); end
      n_vec++; if (period_strobe !== 1'b0) begin n_err++; $display("FAIL reset_strobe: got %b want 0", period_strobe); end
      n_vec++; if (square_out !== 1'b0)   begin n_err++; $display("FAIL reset_square: got %b want 0", square_out); end
      do_reset();
   endtask

   task automatic test_lock;
      int bad_sq  = 0;
      int bad_stb = 0;
      do_reset();
      for (int i = 0; i <= 300; i++) begin
         step(wave(i, 100));
         if (square_out !== ((i % 100) < 50)) bad_sq++;
         if (period_strobe !== ((i % 100 == 0) && (i > 0))) bad_stb++;
         if (i == 0) begin
            n_vec++; if (period_valid !== 1'b0) begin n_err++; $display("FAIL lock_first_edge_valid: got %b want 0", period_valid); end
         end
         if (i == 100) begin
            n_vec++; if (period_out !== 11'd100) begin n_err++; $display("FAIL lock_period: got %0d want 100", period_out); end
            n_vec++; if (period_valid !== 1'b1)  begin n_err++; $display("FAIL lock_valid: got %b want 1", period_valid); end
         end
      end
      n_vec++; if (bad_sq !== 0)  begin n_err++; $display("FAIL lock_square: bad cycles %0d want 0", bad_sq); end
      n_vec++; if (bad_stb !== 0) begin n_err++; $display("FAIL lock_strobe_cadence: bad cycles %0d want 0", bad_stb); end
   endtask

   task automatic test_hysteresis;
      int hits_sq  = 0;
      int hits_stb = 0;
      int hits_val = 0;
      do_reset();
      for (int i = 0; i < 5000; i++) begin
         int t;
         t = ((i * 37) % 401) - 200;
         step(16'(t));
         if (square_out !== 1'b0)    hits_sq++;
         if (period_strobe !== 1'b0) hits_stb++;
         if (period_valid !== 1'b0)  hits_val++;
      end
      n_vec++; if (hits_sq !== 0)  begin n_err++; $display("FAIL hyst_square: high cycles %0d want 0", hits_sq); end
      n_vec++; if (hits_stb !== 0) begin n_err++; $display("FAIL hyst_strobe: strobes %0d want 0", hits_stb); end
      n_vec++; if (hits_val !== 0) begin n_err++; $display("FAIL hyst_valid: valid cycles %0d want 0", hits_val); end
   endtask

   task automatic test_glitch;
      int bad_sq  = 0;
      int bad_stb = 0;
      do_reset();
      for (int i = 0; i <= 300; i++) begin
         // One low sample 4 samples after the edge at 100 makes a glitch rise at 105.
         step((i == 104) ? -16'sd10000 : wave(i, 100));
         if (square_out !== ((i == 104) ? 1'b0 : ((i % 100) < 50))) bad_sq++;
         if (period_strobe !== ((i % 100 == 0) && (i > 0))) bad_stb++;
         if (i == 200 || i == 300) begin
            n_vec++; if (period_out !== 11'd100) begin n_err++; $display("FAIL glitch_period@%0d: got %0d want 100", i, period_out); end
         end
      end
      n_vec++; if (bad_sq !== 0)  begin n_err++; $display("FAIL glitch_square: bad cycles %0d want 0", bad_sq); end
      n_vec++; if (bad_stb !== 0) begin n_err++; $display("FAIL glitch_strobe_cadence: bad cycles %0d want 0", bad_stb); end
   endtask

   task automatic test_timeout;
      int early_drop = 0;
      do_reset();
      for (int i = 0; i <= 100; i++) step(wave(i, 100));
      // The counter is 1 after the accepted edge, reaches 2047 after 2046 more samples, and times out on the next sample.
      for (int j = 1; j <= 2047; j++) begin
         step(16'sd0);
         if (j < 2047 && period_valid !== 1'b1) early_drop++;
         if (j == 2047) begin
            n_vec++; if (period_valid !== 1'b0)  begin n_err++; $display("FAIL timeout_valid: got %b want 0", period_valid); end
            n_vec++; if (period_out !== 11'd100) begin n_err++; $display("FAIL timeout_hold_period: got %0d want 100", period_out); end
         end
      end
      n_vec++; if (early_drop !== 0) begin n_err++; $display("FAIL timeout_early_drop: cycles %0d want 0", early_drop); end
      for (int i = 50; i <= 200; i++) begin
         step(wave(i, 100));
         if (i == 100) begin
            n_vec++; if (period_strobe !== 1'b0) begin n_err++; $display("FAIL relock_first_strobe: got %b want 0", period_strobe); end
         end
         if (i == 200) begin
            n_vec++; if (period_strobe !== 1'b1) begin n_err++; $display("FAIL relock_strobe: got %b want 1", period_strobe); end
            n_vec++; if (period_out !== 11'd100) begin n_err++; $display("FAIL relock_period: got %0d want 100", period_out); end
            n_vec++; if (period_valid !== 1'b1)  begin n_err++; $display("FAIL relock_valid: got %b want 1", period_valid); end
         end
      end
   endtask

   task automatic test_period_change;
      int exp_i [6] = '{100, 200, 400, 600, 800, 1000};
`ifdef PITCH_TRACK_SMOOTH_EN
      int exp_p [6] = '{100, 100, 125, 143, 157, 167};
`else
      int exp_p [6] = '{100, 100, 200, 200, 200, 200};
`endif
      int got_i [$];
      int got_p [$];
      do_reset();
      for (int i = 0; i <= 1000; i++) begin
         step((i < 200) ? wave(i, 100) : wave(i - 200, 200));
         if (period_strobe === 1'b1) begin
            got_i.push_back(i);
            got_p.push_back(int'(period_out));
         end
      end
      n_vec++; if (got_i.size() !== 6) begin n_err++; $display("FAIL change_strobe_count: got %0d want 6", got_i.size()); end
      for (int k = 0; k < 6 && k < got_i.size(); k++) begin
         n_vec++; if (got_i[k] !== exp_i[k]) begin n_err++; $display("FAIL change_strobe_pos[%0d]: got %0d want %0d", k, got_i[k], exp_i[k]); end
         n_vec++; if (got_p[k] !== exp_p[k]) begin n_err++; $display("FAIL change_period[%0d]: got %0d want %0d", k, got_p[k], exp_p[k]); end
      end
   endtask

   task automatic test_reset_mid;
      do_reset();
      for (int i = 0; i <= 150; i++) step(wave(i, 100));
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++; if (period_out !== '0)      begin n_err++; $display("FAIL midrst_period: got %0d want 0", period_out); end
      n_vec++; if (period_valid !== 1'b0)  begin n_err++; $display("FAIL midrst_valid: got %b want 0", period_valid); end
      n_vec++; if (period_strobe !== 1'b0) begin n_err++; $display("FAIL midrst_strobe: got %b want 0", period_strobe); end
      n_vec++; if (square_out !== 1'b0)    begin n_err++; $display("FAIL midrst_square: got %b want 0", square_out); end
      repeat (2) @(negedge sample_clk);
      rst_n = 1'b1;
      for (int i = 0; i <= 100; i++) begin
         step(wave(i, 100));
         if (i == 0) begin
            n_vec++; if (period_strobe !== 1'b0) begin n_err++; $display("FAIL midrst_first_strobe: got %b want 0", period_strobe); end
         end
         if (i == 100) begin
            n_vec++; if (period_strobe !== 1'b1) begin n_err++; $display("FAIL midrst_relock_strobe: got %b want 1", period_strobe); end
            n_vec++; if (period_out !== 11'd100) begin n_err++; $display("FAIL midrst_relock_period: got %0d want 100", period_out); end
            n_vec++; if (period_valid !== 1'b1)  begin n_err++; $display("FAIL midrst_relock_valid: got %b want 1", period_valid); end
         end
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      sample_in = '0;
      test_reset();
      test_lock();
      test_hysteresis();
      test_glitch();
      test_timeout();
      test_period_change();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
